// File: rtl/sun_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// sun_seq_ctrl_if
// APB bus between the sun-sensor sequencer (master) and the sensor register
// block (slave).
//
// Signals
//   psel, penable, pwrite  master -> slave  transfer control
//   paddr, pwdata          master -> slave  address / write data (32 bit)
//   prdata                 slave -> master  read data (32 bit)
//   pready                 slave -> master  transfer completion
//
// Handshake: a transfer is one SETUP cycle (psel=1, penable=0) followed by
// ACCESS cycles (psel=1, penable=1). The transfer completes on the first
// ACCESS cycle in which pready=1; prdata is only meaningful in that cycle.
// paddr/pwrite/pwdata hold steady from SETUP to completion, and the master
// leaves at least one cycle with psel=0 before the next SETUP.
// ---------------------------------------------------------------------------
interface sun_seq_ctrl_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready
  );
endinterface

// File: rtl/sun_seq_ctrl.sv
// ---------------------------------------------------------------------------
// sun_seq_ctrl
// Runs one sun-sensor frame over APB: writes the control word and the three
// configuration registers, streams xmax*ymax pixels into the pixel register,
// polls the status register until bit 0 is set, then reads back the h and k
// result registers.
//
// Ports
//   pclk, prst            clock, synchronous active-high reset
//   start                 run one frame (honoured only while idle)
//   cfg_threshold/xmax/ymax  frame configuration, latched on accepted start
//   pix_valid, pix_data   pixel stream in; pix_ready out (transfer on both)
//   apb                   APB master port (see sun_seq_ctrl_if)
//   busy                  frame in progress
//   done                  one-cycle pulse on successful completion
//   err                   abort flag, held until the next accepted start
//   h_out, k_out          last successfully read h / k register values
//   dbg_state, dbg_phase  FSM state and APB phase for observation
// ---------------------------------------------------------------------------
module sun_seq_ctrl #(
  parameter int POLL_LIMIT = 255,
  parameter int WAIT_LIMIT = 16
) (
  input  logic         pclk,
  input  logic         prst,
  input  logic         start,
  input  logic [7:0]   cfg_threshold,
  input  logic [7:0]   cfg_xmax,
  input  logic [7:0]   cfg_ymax,
  input  logic         pix_valid,
  input  logic [7:0]   pix_data,
  output logic         pix_ready,
  sun_seq_ctrl_if.master apb,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [31:0]  h_out,
  output logic [31:0]  k_out,
  output logic [3:0]   dbg_state,
  output logic [1:0]   dbg_phase
);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_CTRL, S_WR_THR, S_WR_XMAX, S_WR_YMAX, S_PIX_WAIT,
    S_WR_PIX, S_POLL, S_RD_H, S_RD_K, S_DONE
  } state_t;

  // Phase of the APB transfer owned by the current state. GAP is the
  // mandatory psel=0 cycle after completion; the next state is chosen there.
  typedef enum logic [1:0] {PH_SETUP, PH_ACCESS, PH_GAP} phase_t;

  localparam logic [15:0] WAIT_LAST = 16'(WAIT_LIMIT - 1);
  localparam logic [15:0] POLL_LAST = 16'(POLL_LIMIT);

  state_t      state, state_n;
  phase_t      phase, phase_n;
  logic [7:0]  thr_q, xmax_q, ymax_q, pix_q;
  logic [15:0] pix_cnt, poll_cnt, wait_cnt;
  logic        poll_ok, err_q;
  logic [31:0] h_q, k_q;

  logic        xfer;
  logic [7:0]  addr;
  logic        wr;
  logic [31:0] wdata;

  logic        accept, cfg_bad, xfer_ok, abort, pix_take;

  // Bus decode: which register each transfer state targets.
  always_comb begin
    xfer  = 1'b1;
    addr  = 8'h00;
    wr    = 1'b0;
    wdata = 32'h0;
    case (state)
      S_WR_CTRL: begin addr = 8'h0; wr = 1'b1; wdata = 32'h1; end
      S_WR_THR:  begin addr = 8'h1; wr = 1'b1; wdata = {24'd0, thr_q}; end
      S_WR_XMAX: begin addr = 8'h2; wr = 1'b1; wdata = {24'd0, xmax_q}; end
      S_WR_YMAX: begin addr = 8'h3; wr = 1'b1; wdata = {24'd0, ymax_q}; end
      S_WR_PIX:  begin addr = 8'h4; wr = 1'b1; wdata = {24'd0, pix_q}; end
      S_POLL:    addr = 8'h5;
      S_RD_H:    addr = 8'h8;
      S_RD_K:    addr = 8'h9;
      default:   xfer = 1'b0;
    endcase
  end

  // Next state and single-cycle strobes.
  always_comb begin
    state_n  = state;
    phase_n  = phase;
    accept   = 1'b0;
    cfg_bad  = 1'b0;
    xfer_ok  = 1'b0;
    abort    = 1'b0;
    pix_take = 1'b0;
    if (xfer) begin
      case (phase)
        PH_SETUP: phase_n = PH_ACCESS;
        PH_ACCESS: begin
          if (apb.pready) begin
            xfer_ok = 1'b1;
            phase_n = PH_GAP;
          end else if (wait_cnt == WAIT_LAST) begin
            abort   = 1'b1;
            state_n = S_IDLE;
            phase_n = PH_SETUP;
          end
        end
        PH_GAP: begin
          phase_n = PH_SETUP;
          case (state)
            S_WR_CTRL: state_n = S_WR_THR;
            S_WR_THR:  state_n = S_WR_XMAX;
            S_WR_XMAX: state_n = S_WR_YMAX;
            S_WR_YMAX: state_n = S_PIX_WAIT;
            S_WR_PIX:  state_n = (pix_cnt == 16'd0) ? S_POLL : S_PIX_WAIT;
            S_POLL: begin
              if (poll_ok) begin
                state_n = S_RD_H;
              end else if (poll_cnt >= POLL_LAST) begin
                abort   = 1'b1;
                state_n = S_IDLE;
              end else begin
                state_n = S_POLL;
              end
            end
            S_RD_H:    state_n = S_RD_K;
            S_RD_K:    state_n = S_DONE;
            default:   state_n = S_IDLE;
          endcase
        end
        default: phase_n = PH_SETUP;
      endcase
    end else begin
      phase_n = PH_SETUP;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (cfg_xmax == 8'd0 || cfg_ymax == 8'd0) begin
              cfg_bad = 1'b1;
            end else begin
              accept  = 1'b1;
              state_n = S_WR_CTRL;
            end
          end
        end
        S_PIX_WAIT: begin
          if (pix_valid) begin
            pix_take = 1'b1;
            state_n  = S_WR_PIX;
          end
        end
        // start arriving here is dropped: DONE always returns to IDLE.
        S_DONE:  state_n = S_IDLE;
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      state    <= S_IDLE;
      phase    <= PH_SETUP;
      thr_q    <= 8'd0;
      xmax_q   <= 8'd0;
      ymax_q   <= 8'd0;
      pix_q    <= 8'd0;
      pix_cnt  <= 16'd0;
      poll_cnt <= 16'd0;
      wait_cnt <= 16'd0;
      poll_ok  <= 1'b0;
      err_q    <= 1'b0;
      h_q      <= 32'h0;
      k_q      <= 32'h0;
    end else begin
      state <= state_n;
      phase <= phase_n;
      // Counts ACCESS cycles already spent without pready.
      wait_cnt <= (xfer && phase == PH_ACCESS && !apb.pready) ? wait_cnt + 16'd1 : 16'd0;
      if (accept) begin
        thr_q    <= cfg_threshold;
        xmax_q   <= cfg_xmax;
        ymax_q   <= cfg_ymax;
        pix_cnt  <= {8'd0, cfg_xmax} * {8'd0, cfg_ymax};
        poll_cnt <= 16'd0;
        poll_ok  <= 1'b0;
        err_q    <= 1'b0;
      end
      if (cfg_bad || abort) err_q <= 1'b1;
      if (pix_take) pix_q <= pix_data;
      if (xfer_ok) begin
        case (state)
          S_WR_PIX: pix_cnt <= pix_cnt - 16'd1;
          S_POLL: begin
            poll_cnt <= poll_cnt + 16'd1;
            poll_ok  <= apb.prdata[0];
          end
          S_RD_H:  h_q <= apb.prdata;
          S_RD_K:  k_q <= apb.prdata;
          default: ;
        endcase
      end
    end
  end

  assign apb.psel    = xfer && (phase != PH_GAP);
  assign apb.penable = xfer && (phase == PH_ACCESS);
  assign apb.pwrite  = wr;
  assign apb.paddr   = {24'd0, addr};
  assign apb.pwdata  = wdata;

  assign pix_ready = (state == S_PIX_WAIT);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign err       = err_q;
  assign h_out     = h_q;
  assign k_out     = k_q;
  assign dbg_state = state;
  assign dbg_phase = phase;

endmodule

// File: tb/tb_sun_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sun_seq_ctrl
// Directed bench for sun_seq_ctrl. A register-block responder answers the
// APB bus, a monitor logs every completed transfer as {pwrite, addr, data},
// and each test compares the log against a hand-built expected queue.
// ---------------------------------------------------------------------------
module tb_sun_seq_ctrl;

  // ---------------- clock / reset ----------------
  logic pclk = 1'b0;
  logic prst = 1'b1;
  always #5 pclk = ~pclk;

  logic        start = 1'b0;
  logic [7:0]  cfg_threshold = 8'd0, cfg_xmax = 8'd0, cfg_ymax = 8'd0;
  logic        pix_valid, pix_ready;
  logic [7:0]  pix_data;
  logic        busy, done, err;
  logic [31:0] h_out, k_out;
  logic [3:0]  dbg_state;
  logic [1:0]  dbg_phase;

  sun_seq_ctrl_if bus ();

  sun_seq_ctrl dut (
    .pclk(pclk), .prst(prst), .start(start),
    .cfg_threshold(cfg_threshold), .cfg_xmax(cfg_xmax), .cfg_ymax(cfg_ymax),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .apb(bus), .busy(busy), .done(done), .err(err),
    .h_out(h_out), .k_out(k_out), .dbg_state(dbg_state), .dbg_phase(dbg_phase)
  );

  // ---------------- bookkeeping ----------------
  int vectors = 0;
  int miscompares = 0;
  logic [40:0] exp_q[$];
  logic [40:0] act_q[$];
  int poll_reads = 0, poll_pend = 0, poll_ok_at = 1;
  int done_cnt = 0, psel_cycles = 0, pix_taken = 0, prot_err = 0;
  logic        stall_en = 1'b0;
  logic [31:0] stall_addr = 32'h0;
  logic [31:0] h_val = 32'h0, k_val = 32'h0;
  logic        pix_en = 1'b0, pix_gap = 1'b0;
  logic [7:0]  pix_val = 8'h00;

  // ---------------- register-block responder ----------------
  // Status bit 0 reads as set from read number poll_ok_at onward.
  assign bus.pready = !(stall_en && bus.paddr == stall_addr);
  assign bus.prdata = (bus.paddr == 32'h5) ? ((poll_reads + 1 >= poll_ok_at) ? 32'd1 : 32'd0) :
                      (bus.paddr == 32'h8) ? h_val :
                      (bus.paddr == 32'h9) ? k_val : 32'h0;

  // ---------------- monitor + protocol rules ----------------
  logic        prev_psel = 1'b0, prev_fin = 1'b0;
  logic [64:0] prev_ctl = '0;
  initial begin
    forever begin
      @(negedge pclk);
      // The poll count moves one cycle late so prdata stays put up to the
      // edge that completes the read.
      poll_reads += poll_pend;
      poll_pend = 0;
      if (bus.psel && bus.penable && bus.pready) begin
        act_q.push_back({bus.pwrite, bus.paddr[7:0], bus.pwrite ? bus.pwdata : bus.prdata});
        if (bus.paddr == 32'h5) poll_pend = 1;
      end
      if (bus.psel) psel_cycles++;
      if (done === 1'b1) done_cnt++;
      if (bus.penable && !bus.psel) prot_err++;
      if (bus.psel && bus.penable && !prev_psel) prot_err++;
      if (bus.psel && !bus.penable && prev_psel) prot_err++;
      if (bus.psel && prev_fin) prot_err++;
      if (bus.psel && prev_psel && ({bus.pwrite, bus.paddr, bus.pwdata} !== prev_ctl)) prot_err++;
      if (bus.psel && bus.paddr[31:8] != 24'd0) prot_err++;
      prev_psel = bus.psel;
      prev_fin  = bus.psel && bus.penable && bus.pready;
      prev_ctl  = {bus.pwrite, bus.paddr, bus.pwdata};
    end
  end

  // ---------------- pixel source ----------------
  int pix_cyc = 0;
  initial begin
    pix_valid = 1'b0;
    pix_data  = 8'h00;
    forever begin
      @(negedge pclk);
      pix_cyc++;
      pix_valid = pix_en && (!pix_gap || (pix_cyc % 5 == 0));
      pix_data  = pix_val;
      // pix_ready is stable for the rest of this cycle.
      if (pix_valid && pix_ready) pix_taken++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_start(input logic [7:0] thr, input logic [7:0] x, input logic [7:0] y);
    @(negedge pclk);
    cfg_threshold = thr;
    cfg_xmax      = x;
    cfg_ymax      = y;
    start         = 1'b1;
    @(negedge pclk);
    start = 1'b0;
  endtask

  task automatic clear_sb();
    @(posedge pclk);
    #1;
    exp_q.delete();
    act_q.delete();
    poll_reads = 0; poll_pend = 0; done_cnt = 0;
    psel_cycles = 0; pix_taken = 0; prot_err = 0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge pclk);
    @(posedge pclk);
    #1;
  endtask

  task automatic push_exp(input logic w, input logic [7:0] a, input logic [31:0] d);
    exp_q.push_back({w, a, d});
  endtask

  task automatic wait_done(input int budget, output bit seen);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge pclk);
      n++;
    end
    seen = (done === 1'b1);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    prst = 1'b1; start = 1'b1; cfg_xmax = 8'd2; cfg_ymax = 8'd2; pix_en = 1'b1; pix_val = 8'h10;
    repeat (3) @(negedge pclk);
    vectors++;
    if ({bus.psel, bus.penable, bus.pwrite} !== 3'b000) begin
      miscompares++; $display("FAIL reset_ctl act=%b exp=000", {bus.psel, bus.penable, bus.pwrite});
    end
    vectors++;
    if ({bus.paddr, bus.pwdata} !== 64'h0) begin
      miscompares++; $display("FAIL reset_bus act=%h exp=0", {bus.paddr, bus.pwdata});
    end
    vectors++;
    if ({pix_ready, busy, done, err} !== 4'b0000) begin
      miscompares++; $display("FAIL reset_flags act=%b exp=0000", {pix_ready, busy, done, err});
    end
    vectors++;
    if ({h_out, k_out} !== 64'h0 || dbg_state !== 4'd0) begin
      miscompares++; $display("FAIL reset_hk act=%h/%h st=%0d exp=0", h_out, k_out, dbg_state);
    end
    prst = 1'b0; start = 1'b0;
    clear_sb();
    repeat (4) @(negedge pclk);
    settle(1);
    vectors++;
    if (busy !== 1'b0 || psel_cycles != 0 || pix_taken != 0) begin
      miscompares++; $display("FAIL idle_quiet busy=%b psel=%0d pix=%0d exp=0", busy, psel_cycles, pix_taken);
    end
  endtask

  task automatic test_basic();
    bit seen;
    clear_sb();
    poll_ok_at = 1; h_val = 32'h5; k_val = 32'h7; pix_en = 1'b1; pix_gap = 1'b0; pix_val = 8'h10;
    push_exp(1, 8'h0, 32'h1); push_exp(1, 8'h1, 32'h0F); push_exp(1, 8'h2, 32'h2); push_exp(1, 8'h3, 32'h2);
    repeat (4) push_exp(1, 8'h4, 32'h10);
    push_exp(0, 8'h5, 32'h1); push_exp(0, 8'h8, 32'h5); push_exp(0, 8'h9, 32'h7);
    drive_start(8'h0F, 8'd2, 8'd2);
    vectors++;
    if ({busy, bus.psel, bus.penable, bus.pwrite} !== 4'b1101) begin
      miscompares++; $display("FAIL basic_first_setup act=%b exp=1101", {busy, bus.psel, bus.penable, bus.pwrite});
    end
    vectors++;
    if ({bus.paddr, bus.pwdata} !== {32'h0, 32'h1}) begin
      miscompares++; $display("FAIL basic_first_addr act=%h exp=%h", {bus.paddr, bus.pwdata}, {32'h0, 32'h1});
    end
    wait_done(400, seen);
    vectors++;
    if (!seen || busy !== 1'b1) begin
      miscompares++; $display("FAIL basic_done seen=%0d busy=%b exp=1/1", seen, busy);
    end
    @(negedge pclk);
    vectors++;
    if ({busy, done} !== 2'b00) begin
      miscompares++; $display("FAIL basic_after_done act=%b exp=00", {busy, done});
    end
    settle(2);
    vectors++;
    if (act_q.size() != exp_q.size()) begin
      miscompares++; $display("FAIL basic_count act=%0d exp=%0d", act_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      vectors++;
      if (act_q[i] !== exp_q[i]) begin
        miscompares++; $display("FAIL basic_xfer[%0d] act=%h exp=%h", i, act_q[i], exp_q[i]);
      end
    end
    vectors++;
    if (h_out !== 32'h5 || k_out !== 32'h7) begin
      miscompares++; $display("FAIL basic_hk act=%h/%h exp=5/7", h_out, k_out);
    end
    vectors++;
    if (done_cnt != 1 || pix_taken != 4 || prot_err != 0 || err !== 1'b0) begin
      miscompares++; $display("FAIL basic_misc done=%0d pix=%0d prot=%0d err=%b exp=1/4/0/0", done_cnt, pix_taken, prot_err, err);
    end
  endtask

  task automatic test_poll3();
    bit seen;
    clear_sb();
    poll_ok_at = 3; h_val = 32'hA5A5_0012; k_val = 32'h0000_0C3D;
    push_exp(1, 8'h0, 32'h1); push_exp(1, 8'h1, 32'h0F); push_exp(1, 8'h2, 32'h2); push_exp(1, 8'h3, 32'h2);
    repeat (4) push_exp(1, 8'h4, 32'h10);
    push_exp(0, 8'h5, 32'h0); push_exp(0, 8'h5, 32'h0); push_exp(0, 8'h5, 32'h1);
    push_exp(0, 8'h8, 32'hA5A5_0012); push_exp(0, 8'h9, 32'h0000_0C3D);
    drive_start(8'h0F, 8'd2, 8'd2);
    wait_done(400, seen);
    vectors++;
    if (!seen) begin
      miscompares++; $display("FAIL poll3_done act=timeout exp=done");
    end
    settle(2);
    vectors++;
    if (act_q.size() != exp_q.size()) begin
      miscompares++; $display("FAIL poll3_count act=%0d exp=%0d", act_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      vectors++;
      if (act_q[i] !== exp_q[i]) begin
        miscompares++; $display("FAIL poll3_xfer[%0d] act=%h exp=%h", i, act_q[i], exp_q[i]);
      end
    end
    vectors++;
    if (h_out !== 32'hA5A5_0012 || k_out !== 32'h0000_0C3D || done_cnt != 1) begin
      miscompares++; $display("FAIL poll3_hk act=%h/%h done=%0d exp=a5a50012/00000c3d/1", h_out, k_out, done_cnt);
    end
    poll_ok_at = 1;
  endtask

  task automatic test_cfg_zero();
    bit seen;
    int bad = 0;
    clear_sb();
    drive_start(8'h0F, 8'd0, 8'd2);
    vectors++;
    if ({err, busy, bus.psel} !== 3'b100) begin
      miscompares++; $display("FAIL zero_x act=%b exp=100", {err, busy, bus.psel});
    end
    drive_start(8'h0F, 8'd2, 8'd0);
    vectors++;
    if ({err, busy, bus.psel} !== 3'b100) begin
      miscompares++; $display("FAIL zero_y act=%b exp=100", {err, busy, bus.psel});
    end
    repeat (4) begin
      @(negedge pclk);
      if (busy || bus.psel) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++; $display("FAIL zero_quiet act=%0d exp=0", bad);
    end
    h_val = 32'h11; k_val = 32'h22;
    drive_start(8'h33, 8'd1, 8'd1);
    vectors++;
    if ({err, busy} !== 2'b01) begin
      miscompares++; $display("FAIL zero_clear act=%b exp=01", {err, busy});
    end
    wait_done(300, seen);
    settle(2);
    vectors++;
    if (!seen || act_q.size() != 8 || h_out !== 32'h11 || k_out !== 32'h22 || err !== 1'b0) begin
      miscompares++; $display("FAIL zero_frame seen=%0d n=%0d h=%h k=%h err=%b exp=1/8/11/22/0", seen, act_q.size(), h_out, k_out, err);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    int acc = 0;
    clear_sb();
    stall_en = 1'b1; stall_addr = 32'h1;
    drive_start(8'h0F, 8'd2, 8'd2);
    while (n < 50 && !(bus.psel && bus.penable && bus.paddr == 32'h1)) begin
      @(negedge pclk);
      n++;
    end
    vectors++;
    if (n >= 50) begin
      miscompares++; $display("FAIL tmo_reach act=no_access exp=thr_access");
    end
    acc = 1;
    repeat (15) begin
      @(negedge pclk);
      if (bus.psel && bus.penable) acc++;
    end
    vectors++;
    if (acc != 16) begin
      miscompares++; $display("FAIL tmo_access act=%0d exp=16", acc);
    end
    @(negedge pclk);
    vectors++;
    if ({bus.psel, bus.penable, err, busy} !== 4'b0010) begin
      miscompares++; $display("FAIL tmo_abort act=%b exp=0010", {bus.psel, bus.penable, err, busy});
    end
    stall_en = 1'b0;
    settle(4);
    vectors++;
    if (act_q.size() != 1 || done_cnt != 0 || h_out !== 32'h11 || k_out !== 32'h22 || err !== 1'b1) begin
      miscompares++; $display("FAIL tmo_after n=%0d done=%0d h=%h k=%h err=%b exp=1/0/11/22/1", act_q.size(), done_cnt, h_out, k_out, err);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int cnt = 0;
    int extra = 0;
    clear_sb();
    pix_en = 1'b1; pix_gap = 1'b0;
    drive_start(8'h0F, 8'd2, 8'd1);
    while (n < 300 && cnt < 2) begin
      @(negedge pclk);
      n++;
      if (bus.psel && bus.penable && bus.paddr == 32'h4) cnt++;
    end
    vectors++;
    if (cnt < 2) begin
      miscompares++; $display("FAIL rmid_reach act=%0d exp=2", cnt);
    end
    prst = 1'b1; start = 1'b1;
    @(negedge pclk);
    vectors++;
    if ({bus.psel, bus.penable, bus.pwrite, pix_ready, busy, done, err} !== 7'b0) begin
      miscompares++; $display("FAIL rmid_flags act=%b exp=0000000", {bus.psel, bus.penable, bus.pwrite, pix_ready, busy, done, err});
    end
    vectors++;
    if ({bus.paddr, bus.pwdata, h_out, k_out} !== 128'h0) begin
      miscompares++; $display("FAIL rmid_data act=%h exp=0", {bus.paddr, bus.pwdata, h_out, k_out});
    end
    prst = 1'b0; start = 1'b0;
    repeat (8) begin
      @(negedge pclk);
      if (bus.psel || busy || pix_ready) extra++;
    end
    vectors++;
    if (extra != 0) begin
      miscompares++; $display("FAIL rmid_quiet act=%0d exp=0", extra);
    end
  endtask

  task automatic test_gapped();
    int c = 0;
    int extra = 0;
    bit seen = 0;
    clear_sb();
    pix_en = 1'b1; pix_gap = 1'b1; poll_ok_at = 1; h_val = 32'h33; k_val = 32'h44;
    push_exp(1, 8'h0, 32'h1); push_exp(1, 8'h1, 32'h0F); push_exp(1, 8'h2, 32'h3); push_exp(1, 8'h3, 32'h2);
    repeat (6) push_exp(1, 8'h4, 32'h10);
    push_exp(0, 8'h5, 32'h1); push_exp(0, 8'h8, 32'h33); push_exp(0, 8'h9, 32'h44);
    drive_start(8'h0F, 8'd3, 8'd2);
    while (!seen && c < 3000) begin
      @(negedge pclk);
      c++;
      if (done === 1'b1) begin
        seen  = 1;
        start = 1'b1;
      end else begin
        start = (c % 7 == 3);
      end
    end
    vectors++;
    if (!seen) begin
      miscompares++; $display("FAIL gap_done act=timeout exp=done");
    end
    @(negedge pclk);
    start = 1'b0;
    vectors++;
    if ({busy, bus.psel} !== 2'b00) begin
      miscompares++; $display("FAIL gap_done_start act=%b exp=00", {busy, bus.psel});
    end
    repeat (6) begin
      @(negedge pclk);
      if (bus.psel || busy) extra++;
    end
    vectors++;
    if (extra != 0) begin
      miscompares++; $display("FAIL gap_restart act=%0d exp=0", extra);
    end
    settle(1);
    vectors++;
    if (act_q.size() != exp_q.size()) begin
      miscompares++; $display("FAIL gap_count act=%0d exp=%0d", act_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      vectors++;
      if (act_q[i] !== exp_q[i]) begin
        miscompares++; $display("FAIL gap_xfer[%0d] act=%h exp=%h", i, act_q[i], exp_q[i]);
      end
    end
    vectors++;
    if (pix_taken != 6 || done_cnt != 1 || prot_err != 0 || err !== 1'b0) begin
      miscompares++; $display("FAIL gap_misc pix=%0d done=%0d prot=%0d err=%b exp=6/1/0/0", pix_taken, done_cnt, prot_err, err);
    end
    pix_en = 1'b0; pix_gap = 1'b0;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_basic();
    test_poll3();
    test_cfg_zero();
    test_timeout();
    test_reset_mid();
    test_gapped();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
